// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: general-purpose register bank with a per-register busy
// scoreboard for the pipelined mips32 datapath. It sits between ID (read and
// issue) and WB (write and release).
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   rd_addr    NREAD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    NREAD packed combinational read data, port i at [i*DATA_W +: DATA_W]
//   wb_en      writeback strobe
//   wb_addr    writeback destination register
//   wb_data    writeback data
//   iss_valid  decode presents an instruction for issue
//   iss_src_en per-port flag: rd_addr[i] is a true source operand
//   iss_dst_en instruction writes a destination register
//   iss_dst    destination register
//   iss_ready  combinational: no RAW/WAW hazard, the instruction may issue
//   busy       registered scoreboard bit per register
//   wb_orphan  sticky flag: a writeback hit a register that was not busy
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREAD*ADDR_W-1:0]   rd_addr,
  output logic [NREAD*DATA_W-1:0]   rd_data,
  input  logic                      wb_en,
  input  logic [ADDR_W-1:0]         wb_addr,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      iss_valid,
  input  logic [NREAD-1:0]          iss_src_en,
  input  logic                      iss_dst_en,
  input  logic [ADDR_W-1:0]         iss_dst,
  output logic                      iss_ready,
  output logic [(2**ADDR_W)-1:0]    busy,
  output logic                      wb_orphan
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic [NREG-1:0]   wb_hit_c;
  logic [NREG-1:0]   beff_c;
  logic              orphan_q;
  logic              orphan_set_c;
  logic              fire_c;

  // Hard-wired zero register check.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG == 1) && (a == '0);
  endfunction

  // One-hot decode of the writeback target.
  always_comb begin
    wb_hit_c = '0;
    if (wb_en) wb_hit_c[wb_addr] = 1'b1;
  end

  // Effective busy: a same-cycle release is visible only with the bypass.
  always_comb begin
    beff_c = busy_q;
    if (BYPASS != 0) beff_c = busy_q & ~wb_hit_c;
    if (ZERO_REG == 1) beff_c[0] = 1'b0;
  end

  // Read ports: zero register, then bypass (suppressed during reset), then array.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      logic [ADDR_W-1:0] a;
      a = rd_addr[i*ADDR_W +: ADDR_W];
      if (is_zero(a))
        rd_data[i*DATA_W +: DATA_W] = '0;
      else if ((BYPASS != 0) && !rst && wb_en && (wb_addr == a))
        rd_data[i*DATA_W +: DATA_W] = wb_data;
      else
        rd_data[i*DATA_W +: DATA_W] = mem_q[a];
    end
  end

  // Hazard check: RAW on every enabled source, WAW on the destination.
  always_comb begin
    iss_ready = ~rst;
    for (int unsigned i = 0; i < NREAD; i++) begin
      if (iss_src_en[i] && beff_c[rd_addr[i*ADDR_W +: ADDR_W]]) iss_ready = 1'b0;
    end
    if (iss_dst_en && beff_c[iss_dst]) iss_ready = 1'b0;
  end

  assign fire_c = iss_valid & iss_ready;

  // Next busy: release on writeback, then a new producer claims (set wins).
  always_comb begin
    busy_d = busy_q & ~wb_hit_c;
    if (fire_c && iss_dst_en && !is_zero(iss_dst)) busy_d[iss_dst] = 1'b1;
  end

  // Writeback to a register with no outstanding producer.
  assign orphan_set_c = wb_en && !is_zero(wb_addr) && !busy_q[wb_addr];

  // Register array, scoreboard and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) mem_q[r] <= '0;
      busy_q   <= '0;
      orphan_q <= 1'b0;
    end else begin
      if (wb_en && !is_zero(wb_addr)) mem_q[wb_addr] <= wb_data;
      busy_q <= busy_d;
      if (orphan_set_c) orphan_q <= 1'b1;
    end
  end

  assign busy      = busy_q;
  assign wb_orphan = orphan_q;

endmodule
